// File: rtl/breakout_pkg.sv
// Breakout round constants: state encoding, playfield geometry, overlap helper.
// LIVES_EN selects the three-life mode; otherwise the first miss loses.
package breakout_pkg;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        PLAY  = 2'd1,
        LOST  = 2'd2,
        WON   = 2'd3
    } state_t;

    localparam int H_RES       = 640;
    localparam int V_RES       = 480;
    localparam int BALL_SIZE   = 8;
    localparam int BOARD_W     = 64;
    localparam int BOARD_H     = 8;
    localparam int N_BRICKS    = 6;
    localparam int BRICK_X0    = 8;
    localparam int BRICK_PITCH = 40;
    localparam int BRICK_Y     = 60;
    localparam int BRICK_W     = 32;
    localparam int BRICK_H     = 16;
    localparam int STEP        = 2;
    localparam int CW          = 11;

    localparam int X_MAX  = H_RES - BALL_SIZE;
    localparam int Y_MISS = V_RES - BALL_SIZE;

    localparam logic signed [CW-1:0] DSTEP = CW'(STEP);

`ifdef LIVES_EN
    localparam logic [1:0] LIVES_INIT = 2'd3;
`else
    localparam logic [1:0] LIVES_INIT = 2'd0;
`endif

    // Edges touching count as contact.
    function automatic logic touches(
        input int ax, input int ay,
        input int rx, input int ry,
        input int w,  input int h
    );
        return (ax <= rx + w) && (ax + BALL_SIZE >= rx) &&
               (ay <= ry + h) && (ay + BALL_SIZE >= ry);
    endfunction

endpackage

// File: rtl/brick_hit_detect.sv
// Combinational ball-vs-brick overlap for the whole row;
// only the lowest-index alive brick touched is reported.
module brick_hit_detect
    import breakout_pkg::*;
(
    input  logic signed [CW-1:0] nx,
    input  logic signed [CW-1:0] ny,
    input  logic [N_BRICKS-1:0]  alive,
    output logic                 any_hit,
    output logic [N_BRICKS-1:0]  clear
);

    logic [N_BRICKS-1:0] ov;

    for (genvar i = 0; i < N_BRICKS; i++) begin : g_brick
        assign ov[i] = alive[i] &
                       touches(int'(nx), int'(ny),
                               BRICK_X0 + i * BRICK_PITCH, BRICK_Y,
                               BRICK_W, BRICK_H);
    end

    // Isolate the lowest set bit.
    assign clear   = ov & (~ov + 1'b1);
    assign any_hit = |ov;

endmodule

// File: rtl/ball_controller.sv
// One breakout round: serve, motion, collisions, brick clearing, win/lose.
// Define LIVES_EN for three lives per round; otherwise any miss is LOST.
module ball_controller
    import breakout_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                tick,
    input  logic                pause,
    input  logic                launch,
    input  logic [9:0]          board_x,
    input  logic [9:0]          board_y,
    output logic [9:0]          ball_x,
    output logic [9:0]          ball_y,
    output logic [N_BRICKS-1:0] brick_alive,
    output logic                hit,
    output logic [1:0]          state,
    output logic [1:0]          lives
);

    state_t               st, st_n;
    logic signed [CW-1:0] dx, dy, dx_n, dy_n, nx, ny;
    logic [9:0]           x_n, y_n, serve_x, serve_y;
    logic [N_BRICKS-1:0]  alive_n, clear, alive_left;
    logic [1:0]           lives_n;
    logic                 hit_n, launch_q, launch_rise;
    logic                 any_hit, bounce, miss;

    assign launch_rise = launch & ~launch_q;
    assign serve_x     = board_x + 10'(BOARD_W / 2 - BALL_SIZE / 2);
    assign serve_y     = board_y - 10'(BALL_SIZE);
    assign nx          = $signed({1'b0, ball_x}) + dx;
    assign ny          = $signed({1'b0, ball_y}) + dy;
    assign alive_left  = brick_alive & ~clear;

    // A brick strike in the same tick suppresses the paddle.
    assign bounce = !any_hit && !dy[CW-1] &&
                    touches(int'(nx), int'(ny),
                            int'(board_x), int'(board_y),
                            BOARD_W, BOARD_H);
    assign miss   = !any_hit && !bounce && (int'(ny) >= Y_MISS);

    brick_hit_detect u_detect (
        .nx      (nx),
        .ny      (ny),
        .alive   (brick_alive),
        .any_hit (any_hit),
        .clear   (clear)
    );

    always_comb begin
        st_n    = st;
        x_n     = ball_x;
        y_n     = ball_y;
        dx_n    = dx;
        dy_n    = dy;
        alive_n = brick_alive;
        lives_n = lives;
        hit_n   = 1'b0;
        if (!pause) begin
            unique case (st)
                SERVE: begin
                    x_n = serve_x;
                    y_n = serve_y;
                    if (launch_rise) begin
                        st_n = PLAY;
                        dx_n = DSTEP;
                        dy_n = -DSTEP;
                    end
                end
                PLAY: if (tick) begin
                    if (any_hit) begin
                        alive_n = alive_left;
                        dy_n    = -dy;
                        hit_n   = 1'b1;
                        if (alive_left == '0)
                            st_n = WON;
                    end else if (bounce) begin
                        dy_n = -DSTEP;
                    end
                    if (miss) begin
`ifdef LIVES_EN
                        if (lives > 2'd1) begin
                            lives_n = lives - 2'd1;
                            st_n    = SERVE;
                        end else begin
                            lives_n = 2'd0;
                            st_n    = LOST;
                        end
`else
                        st_n = LOST;
`endif
                    end else begin
                        if (nx[CW-1] || nx == '0) begin
                            x_n  = '0;
                            dx_n = DSTEP;
                        end else if (int'(nx) >= X_MAX) begin
                            x_n  = 10'(X_MAX);
                            dx_n = -DSTEP;
                        end else begin
                            x_n = nx[9:0];
                        end
                        if (bounce) begin
                            y_n = serve_y;
                        end else if (ny[CW-1] || ny == '0) begin
                            y_n  = '0;
                            dy_n = DSTEP;
                        end else begin
                            y_n = ny[9:0];
                        end
                    end
                end
                default: if (launch_rise) begin
                    st_n    = SERVE;
                    alive_n = '1;
                    lives_n = LIVES_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= SERVE;
            ball_x      <= 10'(BOARD_W / 2 - BALL_SIZE / 2);
            ball_y      <= 10'(-BALL_SIZE);
            dx          <= DSTEP;
            dy          <= -DSTEP;
            brick_alive <= '1;
            hit         <= 1'b0;
            lives       <= LIVES_INIT;
            launch_q    <= 1'b0;
        end else begin
            st          <= st_n;
            ball_x      <= x_n;
            ball_y      <= y_n;
            dx          <= dx_n;
            dy          <= dy_n;
            brick_alive <= alive_n;
            hit         <= hit_n;
            lives       <= lives_n;
            launch_q    <= launch;
        end
    end

    assign state = st;

endmodule
